// File: rtl/ipgu_pkg.sv
// ipgu_pkg: shared scheduler state encoding and pyramid geometry constants
package ipgu_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SCALE,
    S_WIN_REQ,
    S_WIN_OUT,
    S_ADVANCE,
    S_DONE
  } ipgu_sched_state_t;
  localparam int IPGU_WIN        = 20;
  localparam int IPGU_IMG_DIM    = 300;
  localparam int IPGU_SCALE_NUM  = 4;
  localparam int IPGU_SCALE_DEN  = 5;
  localparam int IPGU_STRIDE     = 10;
  localparam int IPGU_MAX_LEVELS = 8;
  localparam int IPGU_DIM_W      = 9;
endpackage

// File: rtl/ipgu_pyramid_sched_if.sv
// ipgu_pyramid_sched_if: control, rescale, window-fetch and HEU handshakes of the pyramid scheduler
interface ipgu_pyramid_sched_if #(
  parameter int DIM_W = 9
);
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             scale_req;
  logic [DIM_W-1:0] scale_dim;
  logic             scale_ack;
  logic             win_req;
  logic [DIM_W-1:0] win_x;
  logic [DIM_W-1:0] win_y;
  logic             win_ack;
  logic             out_vld;
  logic             out_rdy;
  logic [2:0]       level;
  logic [15:0]      win_cnt;
  modport master (
    input  start, abort, scale_ack, win_ack, out_rdy,
    output busy, done, scale_req, scale_dim, win_req, win_x, win_y, out_vld, level, win_cnt
  );
  modport slave (
    output start, abort, scale_ack, win_ack, out_rdy,
    input  busy, done, scale_req, scale_dim, win_req, win_x, win_y, out_vld, level, win_cnt
  );
endinterface

// File: rtl/ipgu_win_stepper.sv
// ipgu_win_stepper: raster window-origin counter with stride step, row wrap and last-window flag
module ipgu_win_stepper
  import ipgu_pkg::*;
#(
  parameter int WIN    = IPGU_WIN,
  parameter int STRIDE = IPGU_STRIDE,
  parameter int DIM_W  = IPGU_DIM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             step_i,
  input  logic [DIM_W-1:0] cur_dim_i,
  output logic [DIM_W-1:0] x_o,
  output logic [DIM_W-1:0] y_o,
  output logic             last_o
);
  localparam logic [DIM_W:0]   REACH = (DIM_W+1)'(STRIDE + WIN);
  localparam logic [DIM_W-1:0] STEP  = DIM_W'(STRIDE);
  logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
  logic             x_fit, y_fit;
  assign x_fit  = ({1'b0, x_q} + REACH) <= {1'b0, cur_dim_i};
  assign y_fit  = ({1'b0, y_q} + REACH) <= {1'b0, cur_dim_i};
  assign last_o = !x_fit && !y_fit;
  assign x_o    = x_q;
  assign y_o    = y_q;
  // next origin: step along the row, wrap to the next row, or hold on the last window
  always_comb begin
    x_d = clr_i ? '0 : (step_i && x_fit) ? x_q + STEP : (step_i && y_fit) ? '0 : x_q;
    y_d = clr_i ? '0 : (step_i && !x_fit && y_fit) ? y_q + STEP : y_q;
  end
  // origin registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
endmodule

// File: rtl/ipgu_pyramid_sched.sv
// ipgu_pyramid_sched: walks pyramid levels, requests rescales and sweeps window fetches to the HEU
module ipgu_pyramid_sched
  import ipgu_pkg::*;
#(
  parameter int IMG_DIM    = IPGU_IMG_DIM,
  parameter int WIN        = IPGU_WIN,
  parameter int STRIDE     = IPGU_STRIDE,
  parameter int MAX_LEVELS = IPGU_MAX_LEVELS,
  parameter int DIM_W      = IPGU_DIM_W
) (
  input  logic                 clk,
  input  logic                 rst,
  ipgu_pyramid_sched_if.master io
);
  localparam int SW = DIM_W + 2;
  if (IMG_DIM < WIN) begin : g_bad_dim
    $error("IMG_DIM must be at least WIN");
  end
  if (STRIDE < 1) begin : g_bad_stride
    $error("STRIDE must be at least 1");
  end
  ipgu_sched_state_t state_q;
  logic [DIM_W-1:0]  cur_dim_q;
  logic [DIM_W-1:0]  scale_dim_q;
  logic [2:0]        level_q;
  logic [15:0]       win_cnt_q;
  logic              busy_q, done_q, scale_req_q, win_req_q, out_vld_q;
  logic [SW-1:0]     scaled;
  logic              level_end, last, clr, step;
  logic [DIM_W-1:0]  x, y;
  assign scaled    = ({2'b00, cur_dim_q} * SW'(IPGU_SCALE_NUM)) / SW'(IPGU_SCALE_DEN);
  assign level_end = (({1'b0, level_q} + 4'd1) == 4'(MAX_LEVELS)) || (scaled < SW'(WIN));
  assign clr       = !io.abort && ((state_q == S_IDLE && io.start) || (state_q == S_SCALE && io.scale_ack));
  assign step      = !io.abort && state_q == S_ADVANCE;
  ipgu_win_stepper #(
    .WIN   (WIN),
    .STRIDE(STRIDE),
    .DIM_W (DIM_W)
  ) u_stepper (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .step_i   (step),
    .cur_dim_i(cur_dim_q),
    .x_o      (x),
    .y_o      (y),
    .last_o   (last)
  );
  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.scale_req = scale_req_q;
  assign io.scale_dim = scale_dim_q;
  assign io.win_req   = win_req_q;
  assign io.win_x     = x;
  assign io.win_y     = y;
  assign io.out_vld   = out_vld_q;
  assign io.level     = level_q;
  assign io.win_cnt   = win_cnt_q;
  // scheduler FSM; every handshake output is registered alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_dim_q   <= DIM_W'(IMG_DIM);
      scale_dim_q <= '0;
      level_q     <= '0;
      win_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      scale_req_q <= 1'b0;
      win_req_q   <= 1'b0;
      out_vld_q   <= 1'b0;
    end else if (io.abort) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      scale_req_q <= 1'b0;
      win_req_q   <= 1'b0;
      out_vld_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (io.start) begin
          cur_dim_q <= DIM_W'(IMG_DIM);
          level_q   <= '0;
          win_cnt_q <= '0;
          busy_q    <= 1'b1;
          win_req_q <= 1'b1;
          state_q   <= S_WIN_REQ;
        end
        S_SCALE: if (io.scale_ack) begin
          cur_dim_q   <= scale_dim_q;
          level_q     <= level_q + 3'd1;
          scale_req_q <= 1'b0;
          win_req_q   <= 1'b1;
          state_q     <= S_WIN_REQ;
        end
        S_WIN_REQ: if (io.win_ack) begin
          win_req_q <= 1'b0;
          out_vld_q <= 1'b1;
          state_q   <= S_WIN_OUT;
        end
        S_WIN_OUT: if (io.out_rdy) begin
          out_vld_q <= 1'b0;
          win_cnt_q <= win_cnt_q + {15'd0, win_cnt_q != 16'hFFFF};
          state_q   <= S_ADVANCE;
        end
        S_ADVANCE: if (!last) begin
          win_req_q <= 1'b1;
          state_q   <= S_WIN_REQ;
        end else if (level_end) begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end else begin
          scale_req_q <= 1'b1;
          scale_dim_q <= scaled[DIM_W-1:0];
          state_q     <= S_SCALE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ipgu_pyramid_sched.sv
// tb_ipgu_pyramid_sched: scoreboard and table-driven checks of the pyramid scheduler
module tb_ipgu_pyramid_sched;
  typedef struct {int x; int y; int l;} win_t;
  typedef struct {int x; int y;} rast_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ipgu_pyramid_sched_if #(.DIM_W(9)) ia ();
  ipgu_pyramid_sched_if #(.DIM_W(9)) ib ();
  ipgu_pyramid_sched #(
    .IMG_DIM(40), .WIN(20), .STRIDE(10), .MAX_LEVELS(4), .DIM_W(9)
  ) dut_a (
    .clk(clk), .rst(rst), .io(ia.master)
  );
  ipgu_pyramid_sched dut_b (
    .clk(clk), .rst(rst), .io(ib.master)
  );
  int   checks = 0, failures = 0;
  int   done_a = 0, done_b = 0;
  int   lvl_cnt[8];
  win_t exp_a[$], obs_a[$];
  int   exp_sa[$], obs_sa[$], exp_sb[$], obs_sb[$];
  bit   auto_s = 1'b1, auto_w = 1'b1, auto_r = 1'b1;
  bit   sp = 1'b0, wp = 1'b0, rp = 1'b0, spb = 1'b0, wpb = 1'b0, rpb = 1'b0;
  win_t wa, we;
  rast_t rast[9];
  int   sdim_a[3], sdim_b[7], per_lvl[4];

  task automatic check(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask

  // reference model: enumerate the whole run's rescale targets and window origins
  task automatic build(input int img, input int maxlv, input bit to_b, output int tot);
    int d, nd;
    d = img;
    tot = 0;
    if (to_b) exp_sb.delete();
    else begin
      exp_a.delete();
      exp_sa.delete();
    end
    for (int lv = 0; lv < maxlv; lv++) begin
      if (lv > 0) begin
        nd = d * 4 / 5;
        if (nd < 20) break;
        d = nd;
        if (to_b) exp_sb.push_back(d);
        else exp_sa.push_back(d);
      end
      for (int y = 0; y + 20 <= d; y += 10)
        for (int x = 0; x + 20 <= d; x += 10) begin
          tot++;
          if (!to_b) exp_a.push_back('{x, y, lv});
        end
    end
  endtask

  // responder + scoreboard for the small instance: acks arrive one cycle after a request
  always @(negedge clk) begin
    if (ia.done) done_a++;
    if (auto_s) begin
      ia.scale_ack = ia.scale_req && sp && !ia.scale_ack;
      if (ia.scale_ack) begin
        obs_sa.push_back(int'(ia.scale_dim));
        if (exp_sa.size() == 0) check("scale_unexpected", 1, 0);
        else check("scale_dim_a", ia.scale_dim, exp_sa.pop_front());
      end
    end
    sp = ia.scale_req;
    if (auto_w) begin
      ia.win_ack = ia.win_req && wp && !ia.win_ack;
      if (ia.win_ack) begin
        wa = '{int'(ia.win_x), int'(ia.win_y), int'(ia.level)};
        obs_a.push_back(wa);
        lvl_cnt[ia.level]++;
        if (exp_a.size() == 0) check("win_unexpected", 1, 0);
        else begin
          we = exp_a.pop_front();
          check("win_x", wa.x, we.x);
          check("win_y", wa.y, we.y);
          check("win_level", wa.l, we.l);
        end
      end
    end
    wp = ia.win_req;
    ia.out_rdy = auto_r && ia.out_vld && rp && !ia.out_rdy;
    rp = ia.out_vld;
  end

  // responder + scoreboard for the default-size instance
  always @(negedge clk) begin
    if (ib.done) done_b++;
    ib.scale_ack = ib.scale_req && spb && !ib.scale_ack;
    if (ib.scale_ack) begin
      obs_sb.push_back(int'(ib.scale_dim));
      if (exp_sb.size() == 0) check("scale_unexpected_b", 1, 0);
      else check("scale_dim_b", ib.scale_dim, exp_sb.pop_front());
    end
    spb = ib.scale_req;
    ib.win_ack = ib.win_req && wpb && !ib.win_ack;
    wpb = ib.win_req;
    ib.out_rdy = ib.out_vld && rpb && !ib.out_rdy;
    rpb = ib.out_vld;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_a();
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input string n);
    int c0, k;
    c0 = done_a;
    k = 0;
    while (done_a == c0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(n, done_a - c0, 1);
  endtask

  // 0: out_vld, 1: scale_req, 2: scale_req at level 1
  task automatic wait_a(input int sel, input int budget, input string n);
    int k;
    k = 0;
    while (k < budget && !(sel == 0 ? ia.out_vld : sel == 1 ? ia.scale_req : (ia.scale_req && ia.level == 3'd1))) begin
      @(negedge clk);
      k++;
    end
    check(n, k < budget, 1);
  endtask

  initial begin
    int tot, c0, x0, y0, bad, wreq, k;
    rast    = '{'{0, 0}, '{10, 0}, '{20, 0}, '{0, 10}, '{10, 10}, '{20, 10}, '{0, 20}, '{10, 20}, '{20, 20}};
    sdim_a  = '{32, 25, 20};
    per_lvl = '{9, 4, 1, 1};
    sdim_b  = '{240, 192, 153, 122, 97, 77, 61};
    ia.start = 0; ia.abort = 0; ia.scale_ack = 0; ia.win_ack = 0; ia.out_rdy = 0;
    ib.start = 0; ib.abort = 0; ib.scale_ack = 0; ib.win_ack = 0; ib.out_rdy = 0;
    cyc(3);
    check("rst_busy", ia.busy, 0);
    check("rst_done", ia.done, 0);
    check("rst_scale_req", ia.scale_req, 0);
    check("rst_win_req", ia.win_req, 0);
    check("rst_out_vld", ia.out_vld, 0);
    check("rst_level", ia.level, 0);
    check("rst_win_cnt", ia.win_cnt, 0);
    check("rst_win_xy", {ia.win_x, ia.win_y}, 0);
    check("rst_b_busy", ib.busy, 0);
    rst = 1'b0;
    cyc(2);
    ia.abort = 1'b1;
    ia.start = 1'b1;
    @(negedge clk);
    ia.abort = 1'b0;
    ia.start = 1'b0;
    check("abort_beats_start", ia.busy, 0);
    // full run, raster order, per-level counts, rescale targets
    build(40, 4, 1'b0, tot);
    obs_a.delete();
    obs_sa.delete();
    foreach (lvl_cnt[i]) lvl_cnt[i] = 0;
    c0 = done_a;
    start_a();
    check("busy_after_start", ia.busy, 1);
    wait_done_a(2000, "run1_done_timeout");
    cyc(5);
    check("run1_done_once", done_a - c0, 1);
    check("run1_win_cnt", ia.win_cnt, 15);
    check("run1_busy", ia.busy, 0);
    check("run1_level", ia.level, 3);
    check("run1_sb_empty", exp_a.size() + exp_sa.size(), 0);
    check("run1_scales", obs_sa.size(), 3);
    for (int i = 0; i < 3; i++) check("run1_scale_tbl", (i < obs_sa.size()) ? obs_sa[i] : -1, sdim_a[i]);
    for (int i = 0; i < 4; i++) check("run1_lvl_windows", lvl_cnt[i], per_lvl[i]);
    for (int i = 0; i < 9; i++) begin
      check("raster_x", (i < obs_a.size()) ? obs_a[i].x : -1, rast[i].x);
      check("raster_y", (i < obs_a.size()) ? obs_a[i].y : -1, rast[i].y);
    end
    // HEU stall: window stays valid and stable, no new fetch
    build(40, 4, 1'b0, tot);
    auto_r = 1'b0;
    start_a();
    wait_a(0, 100, "stall_vld_timeout");
    x0 = int'(ia.win_x);
    y0 = int'(ia.win_y);
    bad = 0;
    wreq = 0;
    repeat (50) begin
      @(negedge clk);
      if (!ia.out_vld || int'(ia.win_x) != x0 || int'(ia.win_y) != y0) bad++;
      if (ia.win_req) wreq++;
    end
    check("stall_stable", bad, 0);
    check("stall_no_win_req", wreq, 0);
    check("stall_origin", x0 + y0, 0);
    auto_r = 1'b1;
    wait_done_a(2000, "stall_done_timeout");
    cyc(2);
    check("stall_win_cnt", ia.win_cnt, 15);
    // abort during the second rescale
    build(40, 4, 1'b0, tot);
    auto_s = 1'b0;
    ia.scale_ack = 1'b0;
    c0 = done_a;
    start_a();
    wait_a(1, 500, "abort_scale1_timeout");
    check("abort_scale1_dim", ia.scale_dim, 32);
    ia.scale_ack = 1'b1;
    @(negedge clk);
    ia.scale_ack = 1'b0;
    wait_a(2, 500, "abort_scale2_timeout");
    check("abort_scale2_dim", ia.scale_dim, 25);
    ia.abort = 1'b1;
    @(negedge clk);
    ia.abort = 1'b0;
    check("abort_scale_req", ia.scale_req, 0);
    check("abort_busy", ia.busy, 0);
    check("abort_other_req", {ia.win_req, ia.out_vld}, 0);
    cyc(10);
    check("abort_no_done", done_a - c0, 0);
    check("abort_win_cnt", ia.win_cnt, 13);
    auto_s = 1'b1;
    exp_a.delete();
    exp_sa.delete();
    // start while busy plus a stray win_ack during WIN_OUT
    build(40, 4, 1'b0, tot);
    auto_r = 1'b0;
    c0 = done_a;
    start_a();
    wait_a(0, 100, "stray_vld_timeout");
    x0 = int'(ia.win_x);
    auto_w = 1'b0;
    ia.win_ack = 1'b1;
    ia.start = 1'b1;
    @(negedge clk);
    ia.win_ack = 1'b0;
    ia.start = 1'b0;
    cyc(3);
    auto_w = 1'b1;
    check("stray_out_vld", ia.out_vld, 1);
    check("stray_win_req", ia.win_req, 0);
    check("stray_win_cnt", ia.win_cnt, 0);
    check("stray_win_x", ia.win_x, x0);
    auto_r = 1'b1;
    wait_done_a(2000, "stray_done_timeout");
    cyc(5);
    check("stray_done_once", done_a - c0, 1);
    check("stray_final_cnt", ia.win_cnt, 15);
    check("stray_sb_empty", exp_a.size(), 0);
    // default geometry
    build(300, 8, 1'b1, tot);
    obs_sb.delete();
    c0 = done_b;
    ib.start = 1'b1;
    @(negedge clk);
    ib.start = 1'b0;
    k = 0;
    while (done_b == c0 && k < 30000) begin
      @(negedge clk);
      k++;
    end
    check("dflt_done_timeout", k < 30000, 1);
    cyc(5);
    check("dflt_done_once", done_b - c0, 1);
    check("dflt_win_cnt", ib.win_cnt, 2136);
    check("dflt_win_cnt_model", ib.win_cnt, tot);
    check("dflt_busy", ib.busy, 0);
    check("dflt_scales", obs_sb.size(), 7);
    for (int i = 0; i < 7; i++) check("dflt_scale_tbl", (i < obs_sb.size()) ? obs_sb[i] : -1, sdim_b[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
